// File: rtl/booth_mac_sequencer.sv
// Booth MAC sequencer: accepts signed 4x4 operand pairs, issues them one at a time to a
// radix-2 Booth multiplier, accumulates the signed products and emits the dot-product
// sum, pair count and status flags once the pair marked last completes.
module booth_mac_sequencer #(
    parameter int unsigned ACC_W   = 16,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clock,
    input  logic             reset,
    // operand stream
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    input  logic             in_last,
    // multiplier interface
    output logic [3:0]       mul_a,
    output logic [3:0]       mul_b,
    output logic             mul_start,
    input  logic [7:0]       mul_p,
    input  logic             mul_ready,
    // result stream
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_overflow,
    output logic             out_error
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StOut
    } state_t;

    state_t state_q, state_d;

    logic [3:0]       a_q, a_d;
    logic [3:0]       b_q, b_d;
    logic             last_q, last_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum;
    logic             sum_ovf;

    // Sign-extend the product and form the wrapped sum with its signed-overflow flag.
    always_comb begin
        prod_ext = ACC_W'($signed(mul_p));
        sum      = acc_q + prod_ext;
        sum_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                   (sum[ACC_W-1] != acc_q[ACC_W-1]);
    end

    // Next-state logic: operand capture, accumulation, timeout and result handshake.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        last_d  = last_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        tmo_d   = tmo_q;

        unique case (state_q)
            StIdle: begin
                // in_ready is high in this state, so in_valid alone completes the handshake.
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    last_d  = in_last;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                tmo_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                // Operands stay frozen here: the multiplier re-reads A on every iteration.
                if (mul_ready) begin
                    acc_d = sum;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (sum_ovf) begin
                        ovf_d = 1'b1;
                    end
                    state_d = last_q ? StOut : StIdle;
                end else if (tmo_q == TMO_LAST) begin
                    // Multiplier never answered: abort the vector without accumulating.
                    err_d   = 1'b1;
                    state_d = StOut;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            StOut: begin
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            last_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            last_q  <= last_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    // Outputs come only from registers or the decoded state, never from in_* directly.
    always_comb begin
        in_ready     = (state_q == StIdle);
        mul_start    = (state_q == StIssue);
        out_valid    = (state_q == StOut);
        mul_a        = a_q;
        mul_b        = b_q;
        out_sum      = acc_q;
        out_count    = cnt_q;
        out_overflow = ovf_q;
        out_error    = err_q;
    end

endmodule

// File: tb/tb_booth_mac_sequencer.sv
// Bench for booth_mac_sequencer: behavioural Booth multiplier, scoreboard of expected
// vector results, and cycle-level checks of the issue/hold/return timing.
module tb_booth_mac_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid, in_ready, in_last;
    logic [3:0]  in_a, in_b;
    logic [3:0]  mul_a, mul_b;
    logic        mul_start;
    logic [7:0]  mul_p;
    logic        mul_ready;
    logic        out_valid, out_ready;
    logic [15:0] out_sum;
    logic [3:0]  out_count;
    logic        out_overflow, out_error;

    // narrow-accumulator instance sharing all inputs
    logic        in_ready8, mul_start8, out_valid8, out_overflow8, out_error8;
    logic [3:0]  mul_a8, mul_b8, out_count8;
    logic [7:0]  out_sum8;

    always #5 clock = ~clock;

    booth_mac_sequencer #(.ACC_W(16), .CNT_W(4), .TIMEOUT(15)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start), .mul_p(mul_p),
        .mul_ready(mul_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_count(out_count), .out_overflow(out_overflow), .out_error(out_error)
    );

    booth_mac_sequencer #(.ACC_W(8), .CNT_W(4), .TIMEOUT(15)) dut8 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready8), .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .mul_a(mul_a8), .mul_b(mul_b8), .mul_start(mul_start8), .mul_p(mul_p),
        .mul_ready(mul_ready),
        .out_valid(out_valid8), .out_ready(out_ready), .out_sum(out_sum8),
        .out_count(out_count8), .out_overflow(out_overflow8), .out_error(out_error8)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_out    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // ---------------- multiplier model: ready in the 6th cycle after start ----------------
    bit         mul_dead = 1'b0;
    logic       busy;
    logic [2:0] dly;
    logic [3:0] b_cap;

    function automatic logic [7:0] booth_prod(input logic [3:0] a, input logic [3:0] b);
        int x;
        x = int'($signed(a)) * int'($signed(b));
        return x[7:0];
    endfunction

    // A is read at the end of the run, so a moving mul_a corrupts the product.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy <= 1'b0; dly <= '0; b_cap <= '0; mul_ready <= 1'b0; mul_p <= '0;
        end else begin
            mul_ready <= 1'b0;
            mul_p     <= 8'h77;
            if (busy) begin
                if (dly == 0) begin
                    busy <= 1'b0;
                    if (!mul_dead) begin
                        mul_ready <= 1'b1;
                        mul_p     <= booth_prod(mul_a, b_cap);
                    end
                end else begin
                    dly <= dly - 3'd1;
                end
            end else if (mul_start) begin
                busy  <= 1'b1;
                dly   <= 3'd4;
                b_cap <= mul_b;
            end
        end
    end

    // ---------------- reference accumulator and scoreboard ----------------
    typedef struct {
        logic [15:0] sum16;
        logic [7:0]  sum8;
        logic [3:0]  cnt;
        logic        ovf16;
        logic        ovf8;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   m_acc16, m_acc8, m_cnt;
    bit   m_ovf16, m_ovf8;

    task automatic model_clear();
        m_acc16 = 0; m_acc8 = 0; m_cnt = 0; m_ovf16 = 0; m_ovf8 = 0;
    endtask

    task automatic model_add(input int p);
        int t16, t8;
        t16 = m_acc16 + p;
        t8  = m_acc8 + p;
        if (t16 > 32767) begin m_ovf16 = 1; t16 -= 65536; end
        else if (t16 < -32768) begin m_ovf16 = 1; t16 += 65536; end
        if (t8 > 127) begin m_ovf8 = 1; t8 -= 256; end
        else if (t8 < -128) begin m_ovf8 = 1; t8 += 256; end
        m_acc16 = t16;
        m_acc8  = t8;
        m_cnt   = (m_cnt < 15) ? m_cnt + 1 : 15;
    endtask

    task automatic push_expect(input bit err);
        exp_t e;
        e.sum16 = m_acc16[15:0];
        e.sum8  = m_acc8[7:0];
        e.cnt   = m_cnt[3:0];
        e.ovf16 = m_ovf16;
        e.ovf8  = m_ovf8;
        e.err   = err;
        exp_q.push_back(e);
        model_clear();
    endtask

    // Compare each accepted result against the oldest expectation.
    always @(negedge clock) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_out", out_valid, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                n_out++;
                check_eq("out_sum", out_sum, mon_e.sum16);
                check_eq("out_count", out_count, mon_e.cnt);
                check_eq("out_overflow", out_overflow, mon_e.ovf16);
                check_eq("out_error", out_error, mon_e.err);
                check_eq("out_sum8", out_sum8, mon_e.sum8);
                check_eq("out_overflow8", out_overflow8, mon_e.ovf8);
                check_eq("out_valid8", out_valid8, 1'b1);
            end
        end
    end

    // ---------------- stimulus ----------------
    // Present a pair, wait for the accept edge and, for nominal runs, check issue timing
    // through cycle 8 (accept edge closes cycle 0). Non-nominal returns in cycle 1.
    task automatic send_pair(input int a, input int b, input bit last, input bit nominal);
        int w;
        int holds;
        logic [3:0] ea, eb;
        ea = a[3:0];
        eb = b[3:0];
        if (nominal) begin
            model_add(a * b);
            if (last) push_expect(1'b0);
        end
        in_a = ea; in_b = eb; in_last = last; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 300) begin
            @(negedge clock);
            w++;
        end
        if (!in_ready) begin
            check_eq("accept_wait", in_ready, 1'b1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clock);
        @(negedge clock);
        // later input changes must have no effect
        in_valid = 1'b0; in_a = ~ea; in_b = ~eb; in_last = ~last;
        if (!nominal) return;
        check_eq("start_pulse", mul_start, 1'b1);
        check_eq("issue_mul_a", mul_a, ea);
        check_eq("issue_mul_b", mul_b, eb);
        holds = 0;
        for (int k = 2; k <= 7; k++) begin
            @(negedge clock);
            if (mul_a !== ea || mul_b !== eb || in_ready !== 1'b0) holds++;
            if (k == 2) check_eq("start_drop", mul_start, 1'b0);
            if (k == 7) check_eq("no_early_out", out_valid, 1'b0);
        end
        check_eq("operand_hold", holds, 0);
        @(negedge clock);
        check_eq("in_ready_back", in_ready, !last);
        check_eq("out_valid_rise", out_valid, last);
    endtask

    initial begin
        int w;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
        model_clear();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_mul_start", mul_start, 1'b0);
        check_eq("rst_mul_ab", {mul_a, mul_b}, 8'h00);
        check_eq("rst_out_sum", out_sum, 16'h0000);
        check_eq("rst_out_count", out_count, 4'h0);
        check_eq("rst_flags", {out_overflow, out_error}, 2'b00);
        reset = 1'b1;
        @(negedge clock);

        // three-pair vector: 6 - 20 - 56 = -70
        send_pair(3, 2, 1'b0, 1'b1);
        send_pair(-4, 5, 1'b0, 1'b1);
        send_pair(7, -8, 1'b1, 1'b1);

        // single pair: 64
        send_pair(-8, -8, 1'b1, 1'b1);

        // 128: fits 16 bits, overflows 8 bits to 0x80
        send_pair(-8, -8, 1'b0, 1'b1);
        send_pair(-8, -8, 1'b1, 1'b1);

        // backpressure on the result with a pair waiting
        @(posedge clock); #1;
        out_ready = 1'b0;
        send_pair(2, 3, 1'b1, 1'b1);
        in_valid = 1'b1; in_a = 4'h1; in_b = 4'hF; in_last = 1'b1;
        repeat (5) begin
            @(negedge clock);
            check_eq("bp_in_ready", in_ready, 1'b0);
            check_eq("bp_no_start", mul_start, 1'b0);
            check_eq("bp_out_valid", out_valid, 1'b1);
            check_eq("bp_sum_frozen", out_sum, 16'h0006);
            check_eq("bp_count_frozen", out_count, 4'h1);
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
        send_pair(1, -1, 1'b1, 1'b1);

        // multiplier never answers
        mul_dead = 1'b1;
        push_expect(1'b1);
        send_pair(5, 5, 1'b0, 1'b0);
        w = 0;
        while (!out_valid && w < 40) begin
            @(negedge clock);
            w++;
        end
        check_eq("timeout_cycles", w, 16);
        @(negedge clock);
        check_eq("err_cleared", out_error, 1'b0);
        check_eq("err_out_valid", out_valid, 1'b0);
        check_eq("err_in_ready", in_ready, 1'b1);
        mul_dead = 1'b0;

        // reset during WAIT of the second pair
        send_pair(2, 2, 1'b0, 1'b1);
        send_pair(3, 3, 1'b0, 1'b0);
        repeat (2) @(negedge clock);
        check_eq("acc_before_reset", out_sum, 16'h0004);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_in_ready", in_ready, 1'b1);
        check_eq("mid_rst_out_valid", out_valid, 1'b0);
        check_eq("mid_rst_mul_start", mul_start, 1'b0);
        check_eq("mid_rst_mul_ab", {mul_a, mul_b}, 8'h00);
        check_eq("mid_rst_out_sum", out_sum, 16'h0000);
        check_eq("mid_rst_out_count", out_count, 4'h0);
        model_clear();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        send_pair(1, 1, 1'b1, 1'b1);

        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(negedge clock);
            w++;
        end
        check_eq("queue_drained", exp_q.size(), 0);
        check_eq("outputs_seen", n_out, 7);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/booth_mac_sequencer.md
Name: booth_mac_sequencer

Overview:
- Feeds and consumes the 4-bit radix-2 Booth multiplier (start/ready handshake, 4 iterations, product valid with a one-cycle ready pulse).
- Accepts a stream of signed 4x4 operand pairs on a valid/ready interface and issues them to the multiplier one at a time.
- Holds the multiplicand stable while the multiplier runs and accumulates the signed 8-bit products.
- Emits the dot-product sum, pair count and status flags when the pair marked last completes.

Parameters:
- ACC_W, 16, accumulator/out_sum width in bits (>= 8)
- CNT_W, 4, pair counter width; count saturates at 2^CNT_W-1
- TIMEOUT, 15, max cycles spent in WAIT before declaring a multiplier fault (>= 7)

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  sequencer can accept a pair
- in_a  input  4  signed multiplicand
- in_b  input  4  signed multiplier
- in_last  input  1  pair is last of vector
- mul_a  output  4  to multiplier A
- mul_b  output  4  to multiplier B
- mul_start  output  1  to multiplier start
- mul_p  input  8  signed product from multiplier P
- mul_ready  input  1  multiplier ready pulse
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_sum  output  ACC_W  signed accumulated sum
- out_count  output  CNT_W  pairs accumulated (saturating)
- out_overflow  output  1  sticky signed overflow during vector
- out_error  output  1  multiplier timeout occurred in vector

Behaviour:
- Reset (asynchronous, active-low): state IDLE, accumulator/count/flags 0. All outputs 0 except in_ready=1.
- All outputs are registered or decoded from state only; no combinational in_* to out_* paths.
- States: IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_a/in_b/in_last into mul_a/mul_b/last_r, then go to ISSUE.
- ISSUE:
  - in_ready=0; mul_start=1 for exactly this one cycle; go to WAIT.
  - Timeout counter cleared.
- WAIT:
  - mul_a/mul_b held constant. The multiplier reads A every iteration, so mul_a must not change until mul_ready is seen.
  - On mul_ready=1:
    - acc <= acc + sign_extend(mul_p).
    - count <= count+1, saturating.
    - overflow sticky-set if the sign of both addends matches and differs from the sign of the result; the sum wraps.
    - Then go to OUT if last_r, else IDLE.
  - Timeout counter increments each WAIT cycle. If it reaches TIMEOUT without mul_ready: set error, skip accumulation, go to OUT (vector aborted, any remaining pairs are treated as a new vector).
- OUT:
  - out_valid=1; out_sum/out_count/out_overflow/out_error are stable while out_valid=1 and out_ready=0.
  - in_ready=0.
  - On out_ready=1: clear acc/count/flags and go to IDLE. out_valid drops the next cycle.
- mul_ready seen outside WAIT is ignored.
- Nominal timing with this multiplier:
  - Handshake cycle 0, ISSUE cycle 1, mul_ready in cycle 7, accumulation at end of cycle 7, in_ready=1 again in cycle 8.
  - Throughput: 1 pair per 8 cycles.
  - out_valid rises the cycle after the last pair's mul_ready.
- Reset mid-operation: immediate return to the reset state. The multiplier shares the reset, so no stale mul_ready follows.
- in_a/in_b/in_last are sampled only on the accept edge; later input changes have no effect.

Test Plan:
- Vector (3,2),(-4,5),(7,-8) with last on the third pair, out_ready=1. Required: out_sum=-70 (16'hFFBA), out_count=3, overflow=0, error=0. Each mul_start is a 1-cycle pulse; mul_a is constant from ISSUE through mul_ready; in_ready high again 8 cycles after each accept.
- Single pair (-8,-8), last=1. Required: out_sum=64 (16'h0040), out_count=1. out_valid asserted the cycle after mul_ready.
- ACC_W=8, pairs (-8,-8),(-8,-8), last on the second. Required: out_sum=8'h80 (-128), out_overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid with in_valid=1. Required: outputs frozen, in_ready=0, no pair accepted. Release out_ready, then the pair is accepted 2 cycles later and the accumulator starts from 0.
- mul_ready tied 0. Required: WAIT exits after TIMEOUT=15 cycles with out_error=1, out_sum=0, out_count=0. Errors clear after the out handshake.
- Assert reset during WAIT of the second pair. Required: all outputs 0 and in_ready=1 immediately. Next vector (1,1) last gives out_sum=1, out_count=1.
